// File: rtl/prog_tick_counter_if.sv
// Bundle of per-channel control strobes and status for prog_tick_counter.
// Latency: none, wires only; timing is set by the counter that uses it.
// Backpressure: none; strobes are one-cycle requests and are never stalled.
interface prog_tick_counter_if #(
  parameter int COUNTER_WIDTH = 8,
  parameter int NUM_CH        = 4
);
  logic [NUM_CH-1:0]               start;
  logic [NUM_CH-1:0]               stop;
  logic [NUM_CH-1:0]               one_shot;
  logic [NUM_CH*COUNTER_WIDTH-1:0] limit;
  logic [NUM_CH*COUNTER_WIDTH-1:0] count_out;
  logic [NUM_CH-1:0]               busy;
  logic [NUM_CH-1:0]               done;
  logic                            any_done;

  // Control logic side: issues strobes, watches status.
  modport master (
    output start, stop, one_shot, limit,
    input  count_out, busy, done, any_done
  );

  // Timer side: consumes strobes, reports status.
  modport slave (
    input  start, stop, one_shot, limit,
    output count_out, busy, done, any_done
  );
endinterface

// File: rtl/prog_tick_counter.sv
// Multi-channel programmable terminal-count timer, one-shot or periodic per channel.
// Latency: count=0 the edge after start; done pulses one cycle after count reaches limit.
// Backpressure: none; start/stop act on the edge they are sampled, stop > start > terminal.
module prog_tick_counter #(
  parameter int COUNTER_WIDTH = 8,
  parameter int NUM_CH        = 4
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  prog_tick_counter_if.slave     bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                                 state_q [NUM_CH];
  state_t                                 state_d [NUM_CH];
  logic [NUM_CH-1:0][COUNTER_WIDTH-1:0]   cnt_q;
  logic [NUM_CH-1:0][COUNTER_WIDTH-1:0]   cnt_d;
  logic [NUM_CH-1:0][COUNTER_WIDTH-1:0]   lim_q;
  logic [NUM_CH-1:0][COUNTER_WIDTH-1:0]   lim_d;
  logic [NUM_CH-1:0]                      mode_q;
  logic [NUM_CH-1:0]                      mode_d;
  logic [NUM_CH-1:0]                      done_q;
  logic [NUM_CH-1:0]                      done_d;
  logic [NUM_CH-1:0]                      busy_w;

  // State, count, sampled limit/mode and done registers for every channel.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
      end
      cnt_q  <= '0;
      lim_q  <= '0;
      mode_q <= '0;
      done_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
      end
      cnt_q  <= cnt_d;
      lim_q  <= lim_d;
      mode_q <= mode_d;
      done_q <= done_d;
    end
  end

  // Per-channel next state: stop beats start, start beats terminal, terminal beats increment.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    mode_d  = mode_q;
    done_d  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      unique case (state_q[i])
        IDLE: begin
          // stop is meaningless here, so start alone decides.
          if (bus.start[i]) begin
            state_d[i] = RUN;
            cnt_d[i]   = '0;
            lim_d[i]   = bus.limit[i*COUNTER_WIDTH +: COUNTER_WIDTH];
            mode_d[i]  = bus.one_shot[i];
          end
        end
        RUN: begin
          if (bus.stop[i]) begin
            // Abort leaves the count frozen so software can see where it stopped.
            state_d[i] = IDLE;
          end else if (bus.start[i]) begin
            cnt_d[i]   = '0;
            lim_d[i]   = bus.limit[i*COUNTER_WIDTH +: COUNTER_WIDTH];
            mode_d[i]  = bus.one_shot[i];
          end else if (cnt_q[i] == lim_q[i]) begin
            // Equality is checked before incrementing, so limit = all-ones never overflows.
            done_d[i] = 1'b1;
            cnt_d[i]  = '0;
            if (mode_q[i]) begin
              state_d[i] = IDLE;
            end else begin
              lim_d[i]  = bus.limit[i*COUNTER_WIDTH +: COUNTER_WIDTH];
              mode_d[i] = bus.one_shot[i];
            end
          end else begin
            cnt_d[i] = cnt_q[i] + COUNTER_WIDTH'(1);
          end
        end
        default: begin
          state_d[i] = IDLE;
        end
      endcase
    end
  end

  // busy is a straight decode of the registered state.
  always_comb begin
    busy_w = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      busy_w[i] = (state_q[i] == RUN);
    end
  end

  assign bus.count_out = cnt_q;
  assign bus.busy      = busy_w;
  assign bus.done      = done_q;
  assign bus.any_done  = |done_q;

endmodule
